rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high (clk rising edge, reset); no parameters, all widths fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 write_en  input  1  allocate one entry at tail this cycle.
REQ-005 pd_new_in  input  7  new physical destination register of allocated instruction.
REQ-006 pd_old_in  input  7  previous physical mapping of the destination, freed at retire.
REQ-007 pc_in  input  32  PC of allocated instruction, stored per entry.
REQ-008 fu_alu_done / fu_b_done / fu_mem_done  input  1 each  ALU / branch / memory FU completion strobe.
REQ-009 rob_fu_alu / rob_fu_b / rob_fu_mem  input  5 each  ROB tag completed by the matching FU.
REQ-010 br_mispredict  input  1  branch FU reports mispredict.
REQ-011 br_mispredict_tag  input  5  ROB tag of mispredicted branch.
REQ-012 preg_old  output  7  pd_old of entry retired this cycle (freelist return).
REQ-013 valid_retired  output  1  one-cycle pulse per retired entry.
REQ-014 mispredict / mispredict_tag  output  1 / 5  registered copy of br_mispredict / br_mispredict_tag.
REQ-015 full  output  1  high exactly when ctr == 16.
REQ-016 ptr  output  5  current tail index (tag the next allocation receives).

Function
REQ-017 16 entries, tags 0..15 in 5-bit fields; head, tail advance mod 16 (15 -> 0); entry = valid, complete, pd_new, pd_old, pc.
REQ-018 Internal occupancy register named ctr, range 0..16; full = (ctr == 16).
REQ-019 Allocate: write_en && !full at edge -> entry[tail] valid=1, complete=0, fields stored; tail++; write_en while full ignored.
REQ-020 Complete: each fuX_done whose tag hits a valid entry sets complete=1 at edge; up to three per cycle; hits on invalid entries ignored.
REQ-021 Retire: at edge, if entry[head] valid and complete -> invalidate, head++, registered valid_retired=1, preg_old=entry pd_old; else valid_retired=0, preg_old holds.
REQ-022 At most one retire per cycle; strictly in order; incomplete head blocks younger complete entries.
REQ-023 Simultaneous allocate and retire: both occur, ctr unchanged.
REQ-024 Mispredict: br_mispredict with tag of a valid entry -> all entries younger than tag (tag+1 .. tail-1, mod 16) invalidated, tail = tag+1 mod 16, ctr recomputed from head to new tail; branch entry kept.
REQ-025 Mispredict has priority over write_en same cycle (allocation dropped); retire of head proceeds same cycle and is included in ctr.
REQ-026 Mispredict with tag naming an invalid entry ignored (no flush); mispredict/mispredict_tag still registered.
REQ-027 mispredict/mispredict_tag update every cycle from inputs: high exactly one cycle after a one-cycle br_mispredict.
REQ-028 Completion same cycle as flush of that entry: flush wins.

Reset
REQ-029 reset: head=tail=ctr=0, all entries invalid/incomplete, valid_retired=0, preg_old=0, mispredict=0, mispredict_tag=0, full=0, ptr=0; overrides all inputs, any cycle including mid-operation.

Configuration
REQ-030 Macro ROB_SVA_EN: defined -> embedded assertions (ctr <= 16; full == (ctr == 16); no write when full; valid_retired only for complete head) error on violation; undefined -> no assertion code, identical functional behaviour.

Verification
REQ-031 Reset, alloc tags 0,1,2; complete 1 -> no retire; complete 0 -> retire 0 (preg_old=0x10) then 1 (0x11); complete 2 -> retire 2 (0x12); ctr=0.
REQ-032 Alloc tags 3,4,5; complete 5; mispredict tag 3 -> mispredict=1 next cycle only, ptr=4, ctr=1; complete 3 -> retire 3; next alloc gets tag 4.
REQ-033 Fill to ctr=16 wrapping through 15->0 -> full=1; write_en ignored, ptr unchanged; complete+retire two heads -> full=0, ctr=14; alloc succeeds.
REQ-034 Same-cycle alloc and retire at ctr=5 -> ctr stays 5; same-cycle ALU/branch/mem completion of three tags -> all three retire on consecutive cycles.
REQ-035 Reset asserted with ctr=7 and pending mispredict -> all outputs 0, next alloc tag 0.

Source files
------------

// File: rtl/rob.sv
// rob: 16-entry reorder buffer with in-order single retire, three FU completion ports and branch flush.
// Define ROB_SVA_EN to compile the embedded occupancy and retire assertions.
module rob (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_en,
    input  logic [6:0]  pd_new_in,
    input  logic [6:0]  pd_old_in,
    input  logic [31:0] pc_in,
    input  logic        fu_alu_done,
    input  logic        fu_b_done,
    input  logic        fu_mem_done,
    input  logic [4:0]  rob_fu_alu,
    input  logic [4:0]  rob_fu_b,
    input  logic [4:0]  rob_fu_mem,
    input  logic        br_mispredict,
    input  logic [4:0]  br_mispredict_tag,
    output logic [6:0]  preg_old,
    output logic        valid_retired,
    output logic        mispredict,
    output logic [4:0]  mispredict_tag,
    output logic        full,
    output logic [4:0]  ptr
);
    logic [15:0] valid_q, valid_d;
    logic [15:0] complete_q, complete_d;
    logic [3:0]  head_q, head_d;
    logic [3:0]  tail_q, tail_d;
    logic [4:0]  ctr, ctr_d;
    logic [6:0]  pregOld_q, pregOld_d;
    logic        validRetired_q;
    logic        mispredict_q;
    logic [4:0]  mispredictTag_q;

    logic [6:0]  pdNew_q [16];
    logic [6:0]  pdOld_q [16];
    logic [31:0] pc_q    [16];

    logic        allocFire;
    logic        retireFire;
    logic        flushHit;
    logic [3:0]  flushTag;
    logic [3:0]  tagAge;
    logic [3:0]  entryAge;
    logic        unusedPayload;

    assign full           = (ctr == 5'd16);
    assign ptr            = {1'b0, tail_q};
    assign preg_old       = pregOld_q;
    assign valid_retired  = validRetired_q;
    assign mispredict     = mispredict_q;
    assign mispredict_tag = mispredictTag_q;

    // pd_new and pc travel with the entry for the commit path but are not exported on this port list.
    assign unusedPayload = ^{pdNew_q[head_q], pc_q[head_q]};

    assign retireFire = valid_q[head_q] && complete_q[head_q];
    assign flushTag   = br_mispredict_tag[3:0];
    assign flushHit   = br_mispredict && !br_mispredict_tag[4] && valid_q[flushTag];
    assign allocFire  = write_en && !full && !flushHit;
    // Age is distance from head; anything older-than-or-equal to the branch survives a flush.
    assign tagAge     = flushTag - head_q;

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        entryAge   = '0;
        if (fu_alu_done && !rob_fu_alu[4] && valid_q[rob_fu_alu[3:0]])
            complete_d[rob_fu_alu[3:0]] = 1'b1;
        if (fu_b_done && !rob_fu_b[4] && valid_q[rob_fu_b[3:0]])
            complete_d[rob_fu_b[3:0]] = 1'b1;
        if (fu_mem_done && !rob_fu_mem[4] && valid_q[rob_fu_mem[3:0]])
            complete_d[rob_fu_mem[3:0]] = 1'b1;
        if (retireFire) begin
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
        end
        // Flush is applied after completions so a late completion on a squashed entry is lost.
        if (flushHit) begin
            for (int i = 0; i < 16; i++) begin
                entryAge = 4'(i) - head_q;
                if (entryAge > tagAge) begin
                    valid_d[i]    = 1'b0;
                    complete_d[i] = 1'b0;
                end
            end
        end
        if (allocFire) begin
            valid_d[tail_q]    = 1'b1;
            complete_d[tail_q] = 1'b0;
        end
    end

    always_comb begin
        head_d    = retireFire ? head_q + 4'd1 : head_q;
        tail_d    = tail_q;
        ctr_d     = ctr + {4'd0, allocFire} - {4'd0, retireFire};
        pregOld_d = pregOld_q;
        if (flushHit) begin
            tail_d = flushTag + 4'd1;
            ctr_d  = {1'b0, tagAge} + 5'd1 - {4'd0, retireFire};
        end else if (allocFire) begin
            tail_d = tail_q + 4'd1;
        end
        if (retireFire)
            pregOld_d = pdOld_q[head_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= '0;
            complete_q      <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            ctr             <= '0;
            pregOld_q       <= '0;
            validRetired_q  <= 1'b0;
            mispredict_q    <= 1'b0;
            mispredictTag_q <= '0;
        end else begin
            valid_q         <= valid_d;
            complete_q      <= complete_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            ctr             <= ctr_d;
            pregOld_q       <= pregOld_d;
            validRetired_q  <= retireFire;
            mispredict_q    <= br_mispredict;
            mispredictTag_q <= br_mispredict_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (allocFire) begin
            pdNew_q[tail_q] <= pd_new_in;
            pdOld_q[tail_q] <= pd_old_in;
            pc_q[tail_q]    <= pc_in;
        end
    end

`ifdef ROB_SVA_EN
    assert property (@(posedge clk) disable iff (reset) ctr <= 5'd16)
        else $error("rob: occupancy above 16");
    assert property (@(posedge clk) disable iff (reset) full == (ctr == 5'd16))
        else $error("rob: full flag disagrees with occupancy");
    assert property (@(posedge clk) disable iff (reset) !(allocFire && full))
        else $error("rob: allocation while full");
    assert property (@(posedge clk) disable iff (reset) valid_retired |-> $past(retireFire))
        else $error("rob: retire pulse without a complete head");
`else
`endif

endmodule

// File: tb/tb_rob.sv
// tb_rob: scoreboard bench for rob; freelist returns are queued at allocation and
// compared against preg_old whenever valid_retired pulses.
module tb_rob;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [6:0]  pd_new_in = '0;
    logic [6:0]  pd_old_in = '0;
    logic [31:0] pc_in = '0;
    logic        fu_alu_done = 1'b0;
    logic        fu_b_done = 1'b0;
    logic        fu_mem_done = 1'b0;
    logic [4:0]  rob_fu_alu = '0;
    logic [4:0]  rob_fu_b = '0;
    logic [4:0]  rob_fu_mem = '0;
    logic        br_mispredict = 1'b0;
    logic [4:0]  br_mispredict_tag = '0;
    logic [6:0]  preg_old;
    logic        valid_retired;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        full;
    logic [4:0]  ptr;

    typedef struct {
        logic [4:0] tag;
        logic [6:0] pdOld;
    } robEntry_t;

    robEntry_t  robQ[$];
    logic [3:0] modelTail = '0;
    logic [6:0] pdSeq = 7'h40;
    int         compareCount = 0;
    int         mismatchCount = 0;

    rob dut (
        .clk(clk), .reset(reset), .write_en(write_en),
        .pd_new_in(pd_new_in), .pd_old_in(pd_old_in), .pc_in(pc_in),
        .fu_alu_done(fu_alu_done), .fu_b_done(fu_b_done), .fu_mem_done(fu_mem_done),
        .rob_fu_alu(rob_fu_alu), .rob_fu_b(rob_fu_b), .rob_fu_mem(rob_fu_mem),
        .br_mispredict(br_mispredict), .br_mispredict_tag(br_mispredict_tag),
        .preg_old(preg_old), .valid_retired(valid_retired),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .full(full), .ptr(ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // One clock; any retire pulse seen just after the edge is checked against the scoreboard head.
    task automatic step();
        robEntry_t e;
        @(posedge clk);
        #1;
        if (valid_retired) begin
            if (robQ.size() == 0) begin
                checkOutput("unexpectedRetire", 32'(valid_retired), 32'd0);
            end else begin
                e = robQ.pop_front();
                checkOutput("pregOld", 32'(preg_old), 32'(e.pdOld));
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [6:0] pdOld, input logic [2:0] doneMask,
                                 input logic [4:0] aluTag, input logic [4:0] bTag, input logic [4:0] memTag,
                                 input logic mp, input logic [4:0] mpTag);
        robEntry_t e;
        logic hit;
        write_en          = we;
        pd_old_in         = pdOld;
        pd_new_in         = pdOld + 7'd33;
        pc_in             = {23'd0, pdOld, 2'b00};
        fu_alu_done       = doneMask[0];
        fu_b_done         = doneMask[1];
        fu_mem_done       = doneMask[2];
        rob_fu_alu        = aluTag;
        rob_fu_b          = bTag;
        rob_fu_mem        = memTag;
        br_mispredict     = mp;
        br_mispredict_tag = mpTag;
        hit = 1'b0;
        if (mp) begin
            foreach (robQ[k]) begin
                if (robQ[k].tag == mpTag) hit = 1'b1;
            end
        end
        if (hit) begin
            while (robQ[$].tag != mpTag) void'(robQ.pop_back());
            modelTail = mpTag[3:0] + 4'd1;
        end else if (we && robQ.size() < 16) begin
            e.tag   = {1'b0, modelTail};
            e.pdOld = pdOld;
            robQ.push_back(e);
            modelTail = modelTail + 4'd1;
        end
        step();
        write_en      = 1'b0;
        fu_alu_done   = 1'b0;
        fu_b_done     = 1'b0;
        fu_mem_done   = 1'b0;
        br_mispredict = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 7'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic allocEntry(input logic [6:0] pdOld);
        applyStimulus(1'b1, pdOld, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic completeTag(input logic [4:0] tag);
        applyStimulus(1'b0, 7'd0, 3'b001, tag, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic drainAll();
        logic [4:0] tags[$];
        int budget;
        foreach (robQ[k]) tags.push_back(robQ[k].tag);
        foreach (tags[k]) completeTag(tags[k]);
        budget = 40;
        while (robQ.size() != 0 && budget > 0) begin
            idle();
            budget--;
        end
        checkOutput("drainEmpty", 32'(robQ.size()), 32'd0);
        checkOutput("drainCtr", 32'(dut.ctr), 32'd0);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        checkOutput("rstPtr", 32'(ptr), 32'd0);
        checkOutput("rstFull", 32'(full), 32'd0);
        checkOutput("rstRetired", 32'(valid_retired), 32'd0);
        checkOutput("rstPregOld", 32'(preg_old), 32'd0);
        checkOutput("rstMispredict", 32'(mispredict), 32'd0);
        checkOutput("rstCtr", 32'(dut.ctr), 32'd0);

        // In-order retire: younger completion waits behind an incomplete head.
        allocEntry(7'h10);
        allocEntry(7'h11);
        allocEntry(7'h12);
        checkOutput("allocPtr", 32'(ptr), 32'd3);
        checkOutput("allocCtr", 32'(dut.ctr), 32'd3);
        completeTag(5'd1);
        idle();
        checkOutput("headBlocks", 32'(valid_retired), 32'd0);
        completeTag(5'd0);
        checkOutput("noRetireOnCompleteEdge", 32'(valid_retired), 32'd0);
        idle();
        checkOutput("retire0", 32'(valid_retired), 32'd1);
        idle();
        checkOutput("retire1", 32'(valid_retired), 32'd1);
        completeTag(5'd2);
        checkOutput("gapAfterRetire1", 32'(valid_retired), 32'd0);
        idle();
        checkOutput("retire2", 32'(valid_retired), 32'd1);
        checkOutput("emptyCtr", 32'(dut.ctr), 32'd0);

        // Mispredict on tag 3 squashes 4 and 5 and beats a same-cycle allocation.
        allocEntry(7'h23);
        allocEntry(7'h24);
        allocEntry(7'h25);
        checkOutput("ptrBeforeFlush", 32'(ptr), 32'd6);
        completeTag(5'd5);
        applyStimulus(1'b1, 7'h2f, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3);
        checkOutput("mispredictHigh", 32'(mispredict), 32'd1);
        checkOutput("mispredictTag", 32'(mispredict_tag), 32'd3);
        checkOutput("flushPtr", 32'(ptr), 32'd4);
        checkOutput("flushCtr", 32'(dut.ctr), 32'd1);
        idle();
        checkOutput("mispredictOneCycle", 32'(mispredict), 32'd0);
        completeTag(5'd3);
        idle();
        checkOutput("retireBranch", 32'(valid_retired), 32'd1);
        idle();
        checkOutput("squashedNoRetire", 32'(valid_retired), 32'd0);
        checkOutput("ptrAfterFlush", 32'(ptr), 32'd4);
        allocEntry(7'h34);
        checkOutput("reallocPtr", 32'(ptr), 32'd5);
        applyStimulus(1'b1, 7'h35, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9);
        checkOutput("invalidTagPtr", 32'(ptr), 32'd6);
        checkOutput("invalidTagCtr", 32'(dut.ctr), 32'd2);
        checkOutput("invalidTagMispredict", 32'(mispredict), 32'd1);
        checkOutput("invalidTagValue", 32'(mispredict_tag), 32'd9);
        drainAll();

        // Fill across the 15->0 wrap, then confirm allocation is refused until two retires.
        for (int i = 0; i < 16; i++) begin
            allocEntry(pdSeq);
            pdSeq = pdSeq + 7'd1;
        end
        checkOutput("fullFlag", 32'(full), 32'd1);
        checkOutput("fullCtr", 32'(dut.ctr), 32'd16);
        checkOutput("fullPtr", 32'(ptr), 32'd6);
        allocEntry(7'h7f);
        checkOutput("fullIgnoredPtr", 32'(ptr), 32'd6);
        checkOutput("fullIgnoredCtr", 32'(dut.ctr), 32'd16);
        applyStimulus(1'b0, 7'd0, 3'b011, robQ[0].tag, robQ[1].tag, 5'd0, 1'b0, 5'd0);
        idle();
        checkOutput("fullRetireA", 32'(valid_retired), 32'd1);
        idle();
        checkOutput("fullRetireB", 32'(valid_retired), 32'd1);
        checkOutput("notFullFlag", 32'(full), 32'd0);
        checkOutput("notFullCtr", 32'(dut.ctr), 32'd14);
        allocEntry(pdSeq);
        pdSeq = pdSeq + 7'd1;
        checkOutput("allocAfterFull", 32'(dut.ctr), 32'd15);
        checkOutput("allocAfterFullPtr", 32'(ptr), 32'd7);
        drainAll();

        // Same-edge alloc+retire, then three FU completions draining on consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            allocEntry(pdSeq);
            pdSeq = pdSeq + 7'd1;
        end
        checkOutput("fiveCtr", 32'(dut.ctr), 32'd5);
        completeTag(robQ[0].tag);
        allocEntry(pdSeq);
        pdSeq = pdSeq + 7'd1;
        checkOutput("allocRetireRetired", 32'(valid_retired), 32'd1);
        checkOutput("allocRetireCtr", 32'(dut.ctr), 32'd5);
        applyStimulus(1'b0, 7'd0, 3'b111, robQ[0].tag, robQ[1].tag, robQ[2].tag, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("tripleRetire", 32'(valid_retired), 32'd1);
        end
        idle();
        checkOutput("tripleDone", 32'(valid_retired), 32'd0);
        checkOutput("tripleCtr", 32'(dut.ctr), 32'd2);
        drainAll();

        // Reset mid-operation with seven entries and a mispredict in flight.
        for (int i = 0; i < 7; i++) begin
            allocEntry(pdSeq);
            pdSeq = pdSeq + 7'd1;
        end
        checkOutput("sevenCtr", 32'(dut.ctr), 32'd7);
        applyStimulus(1'b0, 7'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, robQ[$].tag);
        checkOutput("youngestFlushCtr", 32'(dut.ctr), 32'd7);
        checkOutput("pendingMispredict", 32'(mispredict), 32'd1);
        reset = 1'b1;
        br_mispredict = 1'b1;
        br_mispredict_tag = 5'd2;
        write_en = 1'b1;
        step();
        reset = 1'b0;
        br_mispredict = 1'b0;
        write_en = 1'b0;
        robQ.delete();
        modelTail = '0;
        checkOutput("midRstRetired", 32'(valid_retired), 32'd0);
        checkOutput("midRstPregOld", 32'(preg_old), 32'd0);
        checkOutput("midRstMispredict", 32'(mispredict), 32'd0);
        checkOutput("midRstMispredictTag", 32'(mispredict_tag), 32'd0);
        checkOutput("midRstFull", 32'(full), 32'd0);
        checkOutput("midRstPtr", 32'(ptr), 32'd0);
        checkOutput("midRstCtr", 32'(dut.ctr), 32'd0);
        allocEntry(7'h55);
        checkOutput("postRstAllocPtr", 32'(ptr), 32'd1);
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
